fp_normalize_round: RTL



---
 rtl/fp_normalize_round_if.sv | 25 ++
 rtl/fp_normalize_round.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fp_normalize_round_if.sv
// Handshake bundle for the FP adder post-addition stage.
// The slave modport is the normalize/round block; the master modport is the producer/consumer side.
interface fp_normalize_round_if #(
    parameter int MANT_W = 26
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [7:0]        in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       fp_out;
    logic              out_ovf;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, fp_out, out_ovf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, fp_out, out_ovf
    );
endinterface

// File: rtl/fp_normalize_round.sv
// Post-addition stage: magnitude, iterative one-shift-per-cycle normalization,
// round-to-nearest-even and IEEE-754 single-precision packing.
module fp_normalize_round #(
    parameter int MANT_W = 26,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_normalize_round_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [MANT_W-1:0] m;
    logic [8:0]        e;
    logic              g;
    logic              t;
    logic              s;
    logic [31:0]       fp_q;
    logic              ovf_q;

    logic              m_zero;
    logic              m_wide;
    logic              m_low;
    logic              round_up;
    logic [MANT_W-1:0] m_rnd;
    logic [MANT_W-1:0] m_fin;
    logic [8:0]        e_fin;

    assign m_zero = (m == '0);
    assign m_wide = |m[MANT_W-1:FRAC_W+1];
    assign m_low  = !m[FRAC_W] && (e > 9'd1);

    // A round carry out of the hidden bit renormalizes to 1.0 with the next exponent.
    always_comb begin
        round_up = g & (t | m[0]);
        m_rnd    = m + MANT_W'(round_up);
        m_fin    = m_rnd;
        e_fin    = e;
        if (m_rnd[FRAC_W+1]) begin
            m_fin = MANT_W'(1) << FRAC_W;
            e_fin = e + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.in_valid) state_next = ABS;
            ABS:   state_next = NORM;
            NORM: begin
                if (m_zero)                 state_next = DONE;
                else if (!m_wide && !m_low) state_next = ROUND;
            end
            ROUND: state_next = DONE;
            DONE:  if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= '0;
            e     <= '0;
            g     <= 1'b0;
            t     <= 1'b0;
            s     <= 1'b0;
            fp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        m <= bus.in_mant;
                        s <= bus.in_sign;
                        e <= (bus.in_exp == 8'd0) ? 9'd1 : {1'b0, bus.in_exp};
                    end
                end
                ABS: begin
                    if (m[MANT_W-1]) m <= ~m + MANT_W'(1);
                    s <= s ^ m[MANT_W-1];
                    g <= 1'b0;
                    t <= 1'b0;
                end
                NORM: begin
                    if (m_zero) begin
                        fp_q  <= '0;
                        ovf_q <= 1'b0;
                    end else if (m_wide) begin
                        t <= t | g;
                        g <= m[0];
                        m <= m >> 1;
                        e <= e + 9'd1;
                    end else if (m_low) begin
                        m <= m << 1;
                        e <= e - 9'd1;
                    end
                end
                ROUND: begin
                    m <= m_fin;
                    e <= e_fin;
                    if (e_fin >= 9'd255) begin
                        fp_q  <= {s, 8'hFF, 23'h0};
                        ovf_q <= 1'b1;
                    end else begin
                        fp_q  <= {s, (m_fin[FRAC_W] ? e_fin[7:0] : 8'h00), m_fin[FRAC_W-1:0]};
                        ovf_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.fp_out    = fp_q;
    assign bus.out_ovf   = ovf_q;

endmodule
